// File: rtl/add_sub_station_if.sv
// Issue, CDB snoop, functional-unit and broadcast signals of the add/sub
// reservation station. The slave modport is the station itself; the master
// modport is its environment (decoder, CDB, functional unit).
interface add_sub_station_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_op;
    logic [2:0] issue_dest;
    logic [8:0] issue_vj;
    logic [8:0] issue_vk;
    logic [2:0] issue_qj;
    logic [2:0] issue_qk;
    logic [2:0] issue_tag;

    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic [8:0] cdb_data;

    logic       fu_run;
    logic [8:0] fu_x;
    logic [8:0] fu_y;
    logic [2:0] fu_op;
    logic [2:0] fu_dest;
    logic [2:0] fu_label;
    logic       fu_done;
    logic [8:0] fu_result;

    logic       bc_valid;
    logic [2:0] bc_tag;
    logic [8:0] bc_data;
    logic [2:0] bc_dest;

    logic       err;

    modport master (
        output issue_valid, issue_op, issue_dest, issue_vj, issue_vk, issue_qj, issue_qk,
        output cdb_valid, cdb_tag, cdb_data,
        output fu_done, fu_result,
        input  issue_ready, issue_tag,
        input  fu_run, fu_x, fu_y, fu_op, fu_dest, fu_label,
        input  bc_valid, bc_tag, bc_data, bc_dest,
        input  err
    );

    modport slave (
        input  issue_valid, issue_op, issue_dest, issue_vj, issue_vk, issue_qj, issue_qk,
        input  cdb_valid, cdb_tag, cdb_data,
        input  fu_done, fu_result,
        output issue_ready, issue_tag,
        output fu_run, fu_x, fu_y, fu_op, fu_dest, fu_label,
        output bc_valid, bc_tag, bc_data, bc_dest,
        output err
    );
endinterface

// File: rtl/add_sub_station.sv
// Three-entry add/sub reservation station: accepts ADD/SUB at issue, snoops
// the CDB for missing operands, sends one ready entry at a time to the
// functional unit and broadcasts its result for exactly one cycle.
module add_sub_station #(
    parameter int unsigned BASE_TAG = 1
) (
    input logic             clk,
    input logic             reset,
    add_sub_station_if.slave bus
);
    localparam int unsigned N    = 3;
    localparam logic [2:0]  TAG0 = 3'(BASE_TAG);

    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

    state_t     state_q, state_d;
    logic [N-1:0] busy_q, disp_q;
    logic [2:0] op_q [N];
    logic [2:0] dest_q [N];
    logic [2:0] qj_q [N];
    logic [2:0] qk_q [N];
    logic [8:0] vj_q [N];
    logic [8:0] vk_q [N];
    logic [1:0] sel_q;

    logic       free_found, rdy_found;
    logic [1:0] free_idx, rdy_idx;
    logic       ready, op_ok, accept, fwd_j, fwd_k;
    logic       dispatch, finish, release_e;

    // Lowest free entry for issue and lowest ready entry for dispatch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
            if (busy_q[i] && !disp_q[i] && qj_q[i] == '0 && qk_q[i] == '0 && !rdy_found) begin
                rdy_found = 1'b1;
                rdy_idx   = 2'(i);
            end
        end
    end

    // Issue handshake, opcode check and same-cycle CDB forwarding.
    always_comb begin
        ready           = free_found && !reset;
        bus.issue_ready = ready;
        bus.issue_tag   = ready ? TAG0 + {1'b0, free_idx} : '0;
        op_ok           = (bus.issue_op == 3'b000) || (bus.issue_op == 3'b001);
        accept          = bus.issue_valid && ready && op_ok;
        fwd_j           = bus.cdb_valid && bus.issue_qj != '0 && bus.cdb_tag == bus.issue_qj;
        fwd_k           = bus.cdb_valid && bus.issue_qk != '0 && bus.cdb_tag == bus.issue_qk;
    end

    // Dispatch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Dispatch FSM next state and one-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        dispatch  = 1'b0;
        finish    = 1'b0;
        release_e = 1'b0;
        case (state_q)
            IDLE: if (rdy_found) begin
                dispatch = 1'b1;
                state_d  = EXEC;
            end
            EXEC: if (bus.fu_done) begin
                finish  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                release_e = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry storage: issue fill, CDB snoop, dispatch mark and release.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            disp_q <= '0;
            sel_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                op_q[i]   <= '0;
                dest_q[i] <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
            end
        end else begin
            if (dispatch) sel_q <= rdy_idx;
            for (int unsigned i = 0; i < N; i++) begin
                // Zero q means "value present", so a zero CDB tag never wakes anything.
                if (busy_q[i] && bus.cdb_valid) begin
                    if (qj_q[i] != '0 && qj_q[i] == bus.cdb_tag) begin
                        vj_q[i] <= bus.cdb_data;
                        qj_q[i] <= '0;
                    end
                    if (qk_q[i] != '0 && qk_q[i] == bus.cdb_tag) begin
                        vk_q[i] <= bus.cdb_data;
                        qk_q[i] <= '0;
                    end
                end
                if (accept && free_idx == 2'(i)) begin
                    busy_q[i] <= 1'b1;
                    disp_q[i] <= 1'b0;
                    op_q[i]   <= bus.issue_op;
                    dest_q[i] <= bus.issue_dest;
                    vj_q[i]   <= fwd_j ? bus.cdb_data : bus.issue_vj;
                    vk_q[i]   <= fwd_k ? bus.cdb_data : bus.issue_vk;
                    qj_q[i]   <= fwd_j ? 3'b000 : bus.issue_qj;
                    qk_q[i]   <= fwd_k ? 3'b000 : bus.issue_qk;
                end
                if (dispatch && rdy_idx == 2'(i)) disp_q[i] <= 1'b1;
                if (release_e && sel_q == 2'(i)) begin
                    busy_q[i] <= 1'b0;
                    disp_q[i] <= 1'b0;
                end
            end
        end
    end

    // Registered functional-unit drive, result broadcast and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.fu_run   <= 1'b0;
            bus.fu_x     <= '0;
            bus.fu_y     <= '0;
            bus.fu_op    <= '0;
            bus.fu_dest  <= '0;
            bus.fu_label <= '0;
            bus.bc_valid <= 1'b0;
            bus.bc_tag   <= '0;
            bus.bc_data  <= '0;
            bus.bc_dest  <= '0;
            bus.err      <= 1'b0;
        end else begin
            bus.err <= bus.issue_valid && ready && !op_ok;
            if (dispatch) begin
                bus.fu_run   <= 1'b1;
                bus.fu_x     <= vj_q[rdy_idx];
                bus.fu_y     <= vk_q[rdy_idx];
                bus.fu_op    <= op_q[rdy_idx];
                bus.fu_dest  <= dest_q[rdy_idx];
                bus.fu_label <= TAG0 + {1'b0, rdy_idx};
            end
            if (finish) begin
                bus.fu_run   <= 1'b0;
                bus.bc_valid <= 1'b1;
                bus.bc_tag   <= bus.fu_label;
                bus.bc_data  <= bus.fu_result;
                bus.bc_dest  <= bus.fu_dest;
            end
            if (release_e) begin
                bus.bc_valid <= 1'b0;
                bus.bc_tag   <= '0;
                bus.bc_data  <= '0;
                bus.bc_dest  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_add_sub_station.sv
// Directed bench for add_sub_station with hand-computed expectations.
module tb_add_sub_station;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    add_sub_station_if bus();

    add_sub_station #(.BASE_TAG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic [2:0] op, input logic [2:0] dest,
                               input logic [8:0] vj, input logic [8:0] vk,
                               input logic [2:0] qj, input logic [2:0] qk);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_dest  = dest;
        bus.issue_vj    = vj;
        bus.issue_vk    = vk;
        bus.issue_qj    = qj;
        bus.issue_qk    = qk;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [8:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.issue_valid = 0; bus.issue_op = 0; bus.issue_dest = 0;
        bus.issue_vj = 0; bus.issue_vk = 0; bus.issue_qj = 0; bus.issue_qk = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.fu_done = 0; bus.fu_result = 0;

        // Reset state
        tick(); tick();
        check("rst_ready", bus.issue_ready, 0);
        check("rst_fu_run", bus.fu_run, 0);
        check("rst_bc_valid", bus.bc_valid, 0);
        check("rst_err", bus.err, 0);
        reset = 1'b0;
        tick();
        check("idle_ready", bus.issue_ready, 1);
        check("idle_tag", bus.issue_tag, 1);

        // ADD 5+3 through the full IDLE/EXEC/WRITE path
        drive_issue(3'b000, 3'd4, 9'd5, 9'd3, 3'd0, 3'd0);
        check("add_tag", bus.issue_tag, 1);
        tick();
        bus.issue_valid = 0;
        check("add_run_c1", bus.fu_run, 0);
        check("add_nexttag", bus.issue_tag, 2);
        tick();
        check("add_run_c2", bus.fu_run, 1);
        check("add_fu_x", bus.fu_x, 5);
        check("add_fu_y", bus.fu_y, 3);
        check("add_fu_op", bus.fu_op, 0);
        check("add_fu_label", bus.fu_label, 1);
        check("add_fu_dest", bus.fu_dest, 4);
        tick(); tick();
        check("add_run_hold", bus.fu_run, 1);
        check("add_x_hold", bus.fu_x, 5);
        bus.fu_done = 1; bus.fu_result = 9'd8;
        tick();
        bus.fu_done = 0;
        check("add_bc_valid", bus.bc_valid, 1);
        check("add_bc_tag", bus.bc_tag, 1);
        check("add_bc_data", bus.bc_data, 8);
        check("add_bc_dest", bus.bc_dest, 4);
        check("add_run_drop", bus.fu_run, 0);
        check("add_write_tag", bus.issue_tag, 2);
        tick();
        check("add_bc_1cyc", bus.bc_valid, 0);
        check("add_freed_tag", bus.issue_tag, 1);

        // SUB 2-7, result wraps to 9'h1FB
        drive_issue(3'b001, 3'd2, 9'd2, 9'd7, 3'd0, 3'd0);
        tick();
        bus.issue_valid = 0;
        tick();
        check("sub_fu_x", bus.fu_x, 2);
        check("sub_fu_y", bus.fu_y, 7);
        check("sub_fu_op", bus.fu_op, 1);
        bus.fu_done = 1; bus.fu_result = 9'h1FB;
        tick();
        bus.fu_done = 0;
        check("sub_bc_data", bus.bc_data, 9'h1FB);
        check("sub_bc_tag", bus.bc_tag, 1);
        tick();

        // Operand waits on tag 5, then CDB delivers 20
        drive_issue(3'b000, 3'd1, 9'd0, 9'd4, 3'd5, 3'd0);
        tick();
        bus.issue_valid = 0;
        tick();
        check("wait_no_run", bus.fu_run, 0);
        cdb(3'd5, 9'd20);
        tick();
        bus.cdb_valid = 0;
        check("snoop_no_run", bus.fu_run, 0);
        tick();
        check("snoop_run", bus.fu_run, 1);
        check("snoop_fu_x", bus.fu_x, 20);
        check("snoop_fu_y", bus.fu_y, 4);
        bus.fu_done = 1; bus.fu_result = 9'd24;
        tick();
        bus.fu_done = 0;
        check("snoop_bc_data", bus.bc_data, 24);
        tick();

        // Forwarding at issue: CDB carries qk's tag on the issue edge
        drive_issue(3'b000, 3'd3, 9'd1, 9'd0, 3'd0, 3'd6);
        cdb(3'd6, 9'd11);
        tick();
        bus.issue_valid = 0; bus.cdb_valid = 0;
        tick();
        check("fwd_run", bus.fu_run, 1);
        check("fwd_fu_y", bus.fu_y, 11);
        bus.fu_done = 1; bus.fu_result = 9'd12;
        tick();
        bus.fu_done = 0;
        tick();

        // Rejected opcode and stray fu_done
        drive_issue(3'b011, 3'd1, 9'd1, 9'd1, 3'd0, 3'd0);
        tick();
        bus.issue_valid = 0;
        check("bad_err", bus.err, 1);
        check("bad_tag", bus.issue_tag, 1);
        bus.fu_done = 1; bus.fu_result = 9'd77;
        tick();
        bus.fu_done = 0;
        check("bad_err_1cyc", bus.err, 0);
        check("bad_no_run", bus.fu_run, 0);
        tick();
        check("stray_done_bc", bus.bc_valid, 0);

        // Three dependent issues fill the station
        drive_issue(3'b000, 3'd1, 9'd0, 9'd20, 3'd7, 3'd0);
        tick();
        drive_issue(3'b001, 3'd2, 9'd0, 9'd1, 3'd1, 3'd0);
        tick();
        drive_issue(3'b000, 3'd3, 9'd5, 9'd0, 3'd0, 3'd2);
        tick();
        check("full_ready", bus.issue_ready, 0);
        drive_issue(3'b000, 3'd6, 9'd9, 9'd9, 3'd0, 3'd0);
        tick();
        bus.issue_valid = 0;
        check("full_ignored", bus.issue_ready, 0);
        check("full_no_err", bus.err, 0);
        check("full_no_run", bus.fu_run, 0);
        cdb(3'd7, 9'd10);
        tick();
        bus.cdb_valid = 0;
        tick();
        check("dep_a_label", bus.fu_label, 1);
        check("dep_a_x", bus.fu_x, 10);
        check("dep_a_y", bus.fu_y, 20);
        bus.fu_done = 1; bus.fu_result = 9'd30;
        tick();
        bus.fu_done = 0;
        check("dep_a_bc_tag", bus.bc_tag, 1);
        check("dep_a_write_full", bus.issue_ready, 0);
        tick();
        check("dep_freed_ready", bus.issue_ready, 1);
        check("dep_freed_tag", bus.issue_tag, 1);
        tick();
        check("no_self_snoop", bus.fu_run, 0);
        cdb(3'd1, 9'd30);
        tick();
        bus.cdb_valid = 0;
        tick();
        check("dep_b_label", bus.fu_label, 2);
        check("dep_b_x", bus.fu_x, 30);
        check("dep_b_op", bus.fu_op, 1);
        bus.fu_done = 1; bus.fu_result = 9'd29;
        tick();
        bus.fu_done = 0;
        check("dep_b_bc_dest", bus.bc_dest, 2);
        tick();
        cdb(3'd2, 9'd29);
        tick();
        bus.cdb_valid = 0;
        tick();
        check("dep_c_label", bus.fu_label, 3);
        check("dep_c_y", bus.fu_y, 29);

        // Reset during EXEC with fu_done on the same edge
        reset = 1'b1;
        bus.fu_done = 1; bus.fu_result = 9'd34;
        tick();
        bus.fu_done = 0;
        check("rexec_bc_valid", bus.bc_valid, 0);
        check("rexec_fu_run", bus.fu_run, 0);
        check("rexec_fu_x", bus.fu_x, 0);
        check("rexec_fu_label", bus.fu_label, 0);
        check("rexec_ready", bus.issue_ready, 0);
        reset = 1'b0;
        tick();
        check("rexec_after_ready", bus.issue_ready, 1);
        check("rexec_after_tag", bus.issue_tag, 1);
        check("rexec_after_bc", bus.bc_valid, 0);
        tick();
        check("rexec_after_run", bus.fu_run, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
